spike_aer_vote_decoder: RTL and testbench



---
 rtl/spike_aer_vote_decoder_pkg.sv | 12 +
 rtl/spike_sat_counter_bank.sv | 42 ++++
 rtl/spike_aer_vote_decoder.sv | 140 ++++++++++++++
 tb/tb_spike_aer_vote_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_aer_vote_decoder_pkg.sv
// Shared constants for the AER vote decoder: address width, defaults and FSM state encodings.
package spike_aer_vote_decoder_pkg;

  localparam int unsigned AerWidth      = 6;
  localparam int unsigned DefNumNeurons = 40;
  localparam int unsigned DefCntWidth   = 8;

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StScan    = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

endpackage

// File: rtl/spike_sat_counter_bank.sv
// Register array of saturating per-neuron spike counters with single-cycle clear and an indexed
// combinational read port.
module spike_sat_counter_bank
  import spike_aer_vote_decoder_pkg::*;
#(
  parameter int unsigned NumNeurons = DefNumNeurons,
  parameter int unsigned CntWidth   = DefCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic [AerWidth-1:0] inc_idx_i,
  input  logic                clr_i,
  input  logic [AerWidth-1:0] rd_idx_i,
  output logic [CntWidth-1:0] rd_data_o
);

  logic [CntWidth-1:0] cnt_q [NumNeurons];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumNeurons; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumNeurons; i++) begin
        if (clr_i) begin
          cnt_q[i] <= '0;
        end else if (inc_i && (inc_idx_i == AerWidth'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Out-of-range read indices return zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NumNeurons; i++) begin
      if (rd_idx_i == AerWidth'(i)) rd_data_o = cnt_q[i];
    end
  end

endmodule

// File: rtl/spike_aer_vote_decoder.sv
// AER spike receiver: counts spikes per neuron over a window of step pulses, then scans for the
// arg-max neuron and offers it downstream with a valid/ready handshake.
module spike_aer_vote_decoder
  import spike_aer_vote_decoder_pkg::*;
#(
  parameter int unsigned NUM_NEURONS  = DefNumNeurons,
  parameter int unsigned CNT_WIDTH    = DefCntWidth,
  parameter int unsigned STEP_WINDOWS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spike_in,
  input  logic [AerWidth-1:0]  spike_AER,
  input  logic                 current_step_finished,
  input  logic                 class_ready,
  output logic                 class_valid,
  output logic [AerWidth-1:0]  class_idx,
  output logic [CNT_WIDTH-1:0] max_count,
  output logic                 spike_dropped
);

  localparam int unsigned StepW = (STEP_WINDOWS > 1) ? $clog2(STEP_WINDOWS) : 1;

  logic [1:0]           state_q, state_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [AerWidth-1:0]  scan_idx_q, scan_idx_d;
  logic [AerWidth-1:0]  best_idx_q, best_idx_d;
  logic [AerWidth-1:0]  class_idx_q, class_idx_d;
  logic [CNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic [CNT_WIDTH-1:0] max_count_q, max_count_d;
  logic                 class_valid_q, class_valid_d;
  logic                 dropped_q, dropped_d;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 in_range, cnt_inc, handshake;

  assign in_range  = {1'b0, spike_AER} < (AerWidth + 1)'(NUM_NEURONS);
  assign cnt_inc   = (state_q == StCollect) && spike_in && in_range;
  assign handshake = (state_q == StDone) && class_valid_q && class_ready;

  spike_sat_counter_bank #(
    .NumNeurons (NUM_NEURONS),
    .CntWidth   (CNT_WIDTH)
  ) u_bank (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .inc_i     (cnt_inc),
    .inc_idx_i (spike_AER),
    .clr_i     (handshake),
    .rd_idx_i  (scan_idx_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    scan_idx_d    = scan_idx_q;
    best_idx_d    = best_idx_q;
    best_cnt_d    = best_cnt_q;
    class_idx_d   = class_idx_q;
    max_count_d   = max_count_q;
    class_valid_d = class_valid_q;
    unique case (state_q)
      StCollect: begin
        if (current_step_finished) begin
          if (step_q == StepW'(STEP_WINDOWS - 1)) begin
            state_d    = StScan;
            step_d     = '0;
            scan_idx_d = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      StScan: begin
        // Strict compare keeps the lowest index on ties.
        if (rd_data > best_cnt_q) begin
          best_cnt_d = rd_data;
          best_idx_d = scan_idx_q;
        end
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == AerWidth'(NUM_NEURONS - 1)) begin
          state_d     = StDone;
          class_idx_d = best_idx_d;
          max_count_d = best_cnt_d;
        end
      end
      StDone: begin
        if (handshake) begin
          state_d       = StCollect;
          class_valid_d = 1'b0;
        end else begin
          class_valid_d = 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_comb begin
    dropped_d = dropped_q;
    if (handshake) begin
      dropped_d = 1'b0;
    end else if ((spike_in && !cnt_inc) ||
                 (current_step_finished && (state_q != StCollect))) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      step_q        <= '0;
      scan_idx_q    <= '0;
      best_idx_q    <= '0;
      best_cnt_q    <= '0;
      class_idx_q   <= '0;
      max_count_q   <= '0;
      class_valid_q <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      scan_idx_q    <= scan_idx_d;
      best_idx_q    <= best_idx_d;
      best_cnt_q    <= best_cnt_d;
      class_idx_q   <= class_idx_d;
      max_count_q   <= max_count_d;
      class_valid_q <= class_valid_d;
      dropped_q     <= dropped_d;
    end
  end

  assign class_valid   = class_valid_q;
  assign class_idx     = class_idx_q;
  assign max_count     = max_count_q;
  assign spike_dropped = dropped_q;

endmodule

// File: tb/tb_spike_aer_vote_decoder.sv
// Directed bench: a default instance (one step per window) and a four-step-window instance.
module tb_spike_aer_vote_decoder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       spike_a, csf_a, ready_a;
  logic [5:0] aer_a;
  logic       valid_a, dropped_a;
  logic [5:0] idx_a;
  logic [7:0] max_a;

  logic       spike_b, csf_b, ready_b;
  logic [5:0] aer_b;
  logic       valid_b, dropped_b;
  logic [5:0] idx_b;
  logic [7:0] max_b;

  int checks = 0;
  int passes = 0;
  int n;

  always #5 clk = ~clk;

  spike_aer_vote_decoder u_dut_a (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .spike_in              (spike_a),
    .spike_AER             (aer_a),
    .current_step_finished (csf_a),
    .class_ready           (ready_a),
    .class_valid           (valid_a),
    .class_idx             (idx_a),
    .max_count             (max_a),
    .spike_dropped         (dropped_a)
  );

  spike_aer_vote_decoder #(
    .STEP_WINDOWS (4)
  ) u_dut_b (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .spike_in              (spike_b),
    .spike_AER             (aer_b),
    .current_step_finished (csf_b),
    .class_ready           (ready_b),
    .class_valid           (valid_b),
    .class_idx             (idx_b),
    .max_count             (max_b),
    .spike_dropped         (dropped_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spikes_a(input logic [5:0] addr, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      spike_a = 1'b1;
      aer_a   = addr;
      tick();
    end
    spike_a = 1'b0;
  endtask

  task automatic pulse_a();
    csf_a = 1'b1;
    tick();
    csf_a = 1'b0;
  endtask

  task automatic spikes_b(input logic [5:0] addr, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      spike_b = 1'b1;
      aer_b   = addr;
      tick();
    end
    spike_b = 1'b0;
  endtask

  task automatic pulse_b();
    csf_b = 1'b1;
    tick();
    csf_b = 1'b0;
  endtask

  // Bounded wait for class_valid; returns the number of edges waited.
  task automatic wait_valid(input bit sel, input string tag, output int cyc);
    cyc = 0;
    while (((sel ? valid_b : valid_a) !== 1'b1) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk(tag, sel ? valid_b : valid_a, 1);
  endtask

  task automatic handshake_a();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    spike_a = 1'b0; csf_a = 1'b0; ready_a = 1'b0; aer_a = '0;
    spike_b = 1'b0; csf_b = 1'b0; ready_b = 1'b0; aer_b = '0;
    repeat (3) tick();
    chk("rst_valid", valid_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_max", max_a, 0);
    chk("rst_dropped", dropped_a, 0);
    chk("rst_valid_b", valid_b, 0);
    rst_n = 1'b1;
    tick();

    // Basic window: 3 spikes at 5, 1 at 7, valid exactly 41 edges after the pulse.
    spikes_a(6'd5, 3);
    spikes_a(6'd7, 1);
    pulse_a();
    repeat (40) tick();
    chk("lat_not_yet", valid_a, 0);
    tick();
    chk("lat_valid", valid_a, 1);
    chk("basic_idx", idx_a, 5);
    chk("basic_max", max_a, 3);
    repeat (10) begin
      tick();
      chk("hold_valid", valid_a, 1);
      chk("hold_idx", idx_a, 5);
      chk("hold_max", max_a, 3);
    end
    handshake_a();
    chk("hs_valid_low", valid_a, 0);

    // Tie goes to the lower index.
    spikes_a(6'd12, 2);
    spikes_a(6'd3, 2);
    pulse_a();
    wait_valid(1'b0, "tie_timeout", n);
    chk("tie_idx", idx_a, 3);
    chk("tie_max", max_a, 2);
    handshake_a();

    // Empty window.
    pulse_a();
    wait_valid(1'b0, "empty_timeout", n);
    chk("empty_idx", idx_a, 0);
    chk("empty_max", max_a, 0);
    handshake_a();
    chk("dropped_clean", dropped_a, 0);

    // Saturation plus out-of-range address.
    spikes_a(6'd39, 300);
    spikes_a(6'd45, 1);
    chk("oor_dropped", dropped_a, 1);
    pulse_a();
    wait_valid(1'b0, "sat_timeout", n);
    chk("sat_idx", idx_a, 39);
    chk("sat_max", max_a, 255);
    handshake_a();
    chk("dropped_cleared", dropped_a, 0);

    // Counters were cleared by the handshake: one spike at 2 must win.
    spikes_a(6'd2, 1);
    pulse_a();
    wait_valid(1'b0, "clr_timeout", n);
    chk("clr_idx", idx_a, 2);
    chk("clr_max", max_a, 1);
    handshake_a();

    // Four-step window on the second instance.
    spikes_b(6'd9, 1);
    pulse_b();
    spikes_b(6'd9, 1);
    pulse_b();
    spikes_b(6'd9, 1);
    pulse_b();
    repeat (45) tick();
    chk("w4_no_scan", valid_b, 0);
    chk("w4_dropped0", dropped_b, 0);
    spike_b = 1'b1;
    aer_b   = 6'd9;
    csf_b   = 1'b1;
    tick();
    csf_b = 1'b0;
    repeat (2) tick();
    spike_b = 1'b0;
    chk("w4_scan_dropped", dropped_b, 1);
    wait_valid(1'b1, "w4_timeout", n);
    chk("w4_latency", n + 2, 41);
    chk("w4_idx", idx_b, 9);
    chk("w4_max", max_b, 4);

    // Asynchronous reset in the middle of a scan.
    spikes_a(6'd10, 3);
    pulse_a();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_idx", idx_a, 0);
    chk("mid_rst_max", max_a, 0);
    chk("mid_rst_valid_b", valid_b, 0);
    chk("mid_rst_dropped_b", dropped_b, 0);
    rst_n = 1'b1;
    tick();
    pulse_a();
    wait_valid(1'b0, "post_rst_timeout", n);
    chk("post_rst_latency", n, 41);
    chk("post_rst_idx", idx_a, 0);
    chk("post_rst_max", max_a, 0);
    handshake_a();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
